// File: rtl/pedestrian_crossing_n.sv
`default_nettype none
// ============================================================================
//  Module      : pedestrian_crossing_n
//  Description : Multi-crosswalk pedestrian controller. Latches button
//                presses, decodes the vehicle phase into per-crosswalk
//                safe flags and runs an independent DONT_WALK/WALK/FLASH
//                timer per crosswalk. Asserts hold_req while any
//                crosswalk is in its walk or clearance interval.
//  Revision    : 1.0  initial release
// ============================================================================
module pedestrian_crossing_n #(
    parameter int                      NUM_XING     = 4,
    parameter int                      STATE_W      = 5,
    parameter int                      WALK_CYCLES  = 8,
    parameter int                      FLASH_CYCLES = 4,
    parameter logic [16*NUM_XING-1:0]  SAFE_MAP     = 64'h00C3
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [STATE_W-1:0]      state1,
    input  logic [NUM_XING-1:0]     ps,
    output logic [2*NUM_XING-1:0]   p_light,
    output logic [NUM_XING-1:0]     req_pend,
    output logic                    hold_req
);

    localparam int c_MAX_CYC = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    // Phase codes are compared after zero-extension so that narrow
    // STATE_W values never alias onto a higher phase index.
    localparam int c_EXT_W   = STATE_W + 32;

    localparam logic [c_CNT_W-1:0] c_WALK_LOAD  = c_CNT_W'(WALK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FLASH_LOAD = c_CNT_W'(FLASH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    // Lamp encoding doubles as the state encoding, so p_light comes
    // straight from the state flops.
    typedef enum logic [1:0] {
        ST_DONT_WALK = 2'b00,
        ST_WALK      = 2'b01,
        ST_FLASH     = 2'b10
    } xing_state_t;

    logic [NUM_XING-1:0] ps_prev_q;
    logic [NUM_XING-1:0] ps_prev_d;
    logic                hold_q;
    logic                hold_d;
    logic [NUM_XING-1:0] w_press;
    logic [NUM_XING-1:0] w_safe;
    logic [NUM_XING-1:0] w_active;
    logic [c_EXT_W-1:0]  w_state_ext;

    // Rising-edge detect on the buttons; a held button counts once.
    always_comb begin
        ps_prev_d = ps;
        w_press   = ps & ~ps_prev_q;
    end

    // Phase decode: phases 0..15 index SAFE_MAP, anything above is unsafe.
    always_comb begin
        w_state_ext = c_EXT_W'(state1);
        w_safe      = '0;
        for (int p = 0; p < 16; p++) begin
            if (w_state_ext == c_EXT_W'(p)) begin
                w_safe = SAFE_MAP[p*NUM_XING +: NUM_XING];
            end
        end
    end

    // Hold tracks the state each crosswalk is entering on this edge.
    always_comb begin
        hold_d = |w_active;
    end

    // Shared registers: button history and the hold request.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            ps_prev_q <= '0;
            hold_q    <= 1'b0;
        end else begin
            ps_prev_q <= ps_prev_d;
            hold_q    <= hold_d;
        end
    end

    assign hold_req = hold_q;

    generate
        for (genvar gi = 0; gi < NUM_XING; gi++) begin : g_xing
            xing_state_t          state_q;
            xing_state_t          state_d;
            logic [c_CNT_W-1:0]   cnt_q;
            logic [c_CNT_W-1:0]   cnt_d;
            logic                 req_q;
            logic                 req_d;

            // Next state, interval counter and request latch for one crosswalk.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                req_d   = req_q | w_press[gi];
                unique case (state_q)
                    ST_DONT_WALK: begin
                        if ((req_q | w_press[gi]) & w_safe[gi]) begin
                            state_d = ST_WALK;
                            cnt_d   = c_WALK_LOAD;
                            // A press landing on the entry edge is served by this walk.
                            req_d   = 1'b0;
                        end
                    end
                    ST_WALK: begin
                        // Losing the safe phase cuts WALK short but still
                        // grants a full clearance interval.
                        if (!w_safe[gi] || (cnt_q == '0)) begin
                            state_d = ST_FLASH;
                            cnt_d   = c_FLASH_LOAD;
                        end else begin
                            cnt_d   = cnt_q - c_CNT_ONE;
                        end
                    end
                    ST_FLASH: begin
                        if (cnt_q == '0) begin
                            state_d = ST_DONT_WALK;
                        end else begin
                            cnt_d   = cnt_q - c_CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_DONT_WALK;
                        cnt_d   = '0;
                    end
                endcase
            end

            // Crosswalk state register; reset drops straight to DONT_WALK.
            always_ff @(posedge CLK) begin
                if (!rst) begin
                    state_q <= ST_DONT_WALK;
                    cnt_q   <= '0;
                    req_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    req_q   <= req_d;
                end
            end

            assign p_light[2*gi +: 2] = state_q;
            assign req_pend[gi]       = req_q;
            assign w_active[gi]       = (state_d != ST_DONT_WALK);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pedestrian_crossing_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pedestrian_crossing_n
//  Description : Self-checking bench for pedestrian_crossing_n. Drives a
//                default build and a 6-crosswalk build, compares both
//                against a timestamp-based model every cycle and adds
//                hand-computed directed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pedestrian_crossing_n;

    logic        CLK;
    logic        rst;
    logic [4:0]  state1;
    logic [3:0]  ps;
    logic [7:0]  p_light;
    logic [3:0]  req_pend;
    logic        hold_req;

    logic        rst2;
    logic [4:0]  st2;
    logic [5:0]  ps2;
    logic [11:0] pl2;
    logic [5:0]  rq2;
    logic        hold2;

    int checks   = 0;
    int failures = 0;

    pedestrian_crossing_n dut_a (
        .CLK      (CLK),
        .rst      (rst),
        .state1   (state1),
        .ps       (ps),
        .p_light  (p_light),
        .req_pend (req_pend),
        .hold_req (hold_req)
    );

    pedestrian_crossing_n #(
        .NUM_XING     (6),
        .STATE_W      (5),
        .WALK_CYCLES  (3),
        .FLASH_CYCLES (2),
        .SAFE_MAP     (96'h0000_0000_3000_0303)
    ) dut_b (
        .CLK      (CLK),
        .rst      (rst2),
        .state1   (st2),
        .ps       (ps2),
        .p_light  (pl2),
        .req_pend (rq2),
        .hold_req (hold2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Each crosswalk is described by the cycle its WALK ends and the cycle
    // its FLASH ends; the lamp at any cycle follows from those two stamps.
    int   m_n = -1;
    int   m_we   [2][6];
    int   m_fe   [2][6];
    logic m_req  [2][6];
    logic m_prev [2][6];

    function automatic int lamp_of(input int we, input int fe, input int t);
        if (t < we)      return 1;
        else if (t < fe) return 2;
        else             return 0;
    endfunction

    task automatic model_step(input int d, input logic r, input logic [5:0] p,
                              input logic [4:0] st, input int nx, input int w,
                              input int f, input logic [95:0] map);
        int   prior;
        logic press;
        logic safe;
        for (int i = 0; i < nx; i++) begin
            if (!r) begin
                m_we[d][i]   = -1;
                m_fe[d][i]   = -1;
                m_req[d][i]  = 1'b0;
                m_prev[d][i] = 1'b0;
            end else begin
                press        = p[i] & ~m_prev[d][i];
                m_prev[d][i] = p[i];
                safe         = (int'(st) < 16) ? map[int'(st)*nx + i] : 1'b0;
                prior        = lamp_of(m_we[d][i], m_fe[d][i], m_n - 1);
                if (prior == 0 && (m_req[d][i] || press) && safe) begin
                    m_we[d][i]  = m_n + w;
                    m_fe[d][i]  = m_n + w + f;
                    m_req[d][i] = 1'b0;
                end else begin
                    if (press) m_req[d][i] = 1'b1;
                    if (prior == 1 && !safe) begin
                        m_we[d][i] = m_n;
                        m_fe[d][i] = m_n + f;
                    end
                end
            end
        end
    endtask

    function automatic logic [11:0] exp_pl(input int d, input int nx);
        logic [11:0] v = '0;
        for (int i = 0; i < nx; i++) v[2*i +: 2] = 2'(lamp_of(m_we[d][i], m_fe[d][i], m_n));
        return v;
    endfunction

    function automatic logic [5:0] exp_req(input int d, input int nx);
        logic [5:0] v = '0;
        for (int i = 0; i < nx; i++) v[i] = m_req[d][i];
        return v;
    endfunction

    function automatic logic exp_hold(input int d, input int nx);
        logic h = 1'b0;
        for (int i = 0; i < nx; i++) if (lamp_of(m_we[d][i], m_fe[d][i], m_n) != 0) h = 1'b1;
        return h;
    endfunction

    // Compare process: advance the model on every edge, check both DUTs just after.
    initial begin
        logic [11:0] epl;
        logic [5:0]  erq;
        forever begin
            @(posedge CLK);
            m_n++;
            model_step(0, rst,  {2'b00, ps}, state1, 4, 8, 4, 96'h00C3);
            model_step(1, rst2, ps2,         st2,    6, 3, 2, 96'h0000_0000_3000_0303);
            #1;
            epl = exp_pl(0, 4);
            erq = exp_req(0, 4);
            check("model_a_p_light",  32'(p_light),  32'(epl[7:0]));
            check("model_a_req_pend", 32'(req_pend), 32'(erq[3:0]));
            check("model_a_hold_req", 32'(hold_req), 32'(exp_hold(0, 4)));
            epl = exp_pl(1, 6);
            erq = exp_req(1, 6);
            check("model_b_p_light",  32'(pl2),   32'(epl));
            check("model_b_req_pend", 32'(rq2),   32'(erq));
            check("model_b_hold_req", 32'(hold2), 32'(exp_hold(1, 6)));
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int nw;
        int nf;
        int nh;
        rst    = 1'b0;
        ps     = 4'(($urandom));
        state1 = 5'(($urandom));
        rst2   = 1'b0;
        ps2    = 6'b0;
        st2    = 5'd17;

        // Reset with random inputs.
        step();
        ps     = 4'(($urandom));
        state1 = 5'(($urandom));
        step();
        check("reset_p_light",  32'(p_light),  32'h0);
        check("reset_req_pend", 32'(req_pend), 32'h0);
        check("reset_hold_req", 32'(hold_req), 32'h0);
        rst    = 1'b1;
        ps     = 4'b0;
        state1 = 5'd0;
        step();

        // Single press in phase n_s: 8 WALK, 4 FLASH, back to DONT_WALK.
        ps = 4'b0001;
        nh = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            ps = 4'b0;
            check("t2_walk", 32'(p_light), 32'h01);
            if (hold_req) nh++;
        end
        for (int j = 0; j < 4; j++) begin
            step();
            check("t2_flash", 32'(p_light), 32'h02);
            if (hold_req) nh++;
        end
        step();
        check("t2_done", 32'(p_light), 32'h00);
        if (hold_req) nh++;
        check("t2_hold_cycles", 32'(nh), 32'd12);

        // Press in an unsafe phase is latched, then served on the safe phase.
        state1 = 5'd2;
        ps     = 4'b0100;
        step();
        ps = 4'b0;
        check("t3_latched", 32'(req_pend), 32'h4);
        check("t3_no_walk", 32'(p_light),  32'h00);
        step();
        step();
        state1 = 5'd1;
        step();
        check("t3_walk",    32'(p_light),  32'h10);
        check("t3_cleared", 32'(req_pend), 32'h0);
        repeat (13) step();

        // Abort: WALK cut short by losing the safe phase, full FLASH follows.
        ps = 4'b1000;
        step();
        ps = 4'b0;
        check("t4_walk1", 32'(p_light), 32'h40);
        step();
        check("t4_walk2", 32'(p_light), 32'h40);
        step();
        check("t4_walk3", 32'(p_light), 32'h40);
        state1 = 5'd3;
        for (int j = 0; j < 4; j++) begin
            step();
            check("t4_flash", 32'(p_light), 32'h80);
        end
        step();
        check("t4_done", 32'(p_light), 32'h00);

        // Phase 16 is beyond the map: press latches but never walks.
        state1 = 5'd16;
        ps     = 4'b0001;
        step();
        ps = 4'b0;
        step();
        step();
        check("t_ph16_no_walk", 32'(p_light),  32'h00);
        check("t_ph16_latched", 32'(req_pend), 32'h1);
        state1 = 5'd0;
        step();
        check("t_ph16_served", 32'(p_light), 32'h01);
        repeat (13) step();

        // Held button gives exactly one WALK/FLASH cycle.
        ps = 4'b0001;
        nw = 0;
        nf = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            if (p_light[1:0] == 2'b01) nw++;
            if (p_light[1:0] == 2'b10) nf++;
        end
        ps = 4'b0;
        check("t5_walk_count",  32'(nw), 32'd8);
        check("t5_flash_count", 32'(nf), 32'd4);
        step();

        // Press during FLASH is re-latched and served after one DONT_WALK clock.
        ps = 4'b0001;
        step();
        ps = 4'b0;
        repeat (8) step();
        check("t5_in_flash", 32'(p_light), 32'h02);
        ps = 4'b0001;
        step();
        ps = 4'b0;
        check("t5_relatched", 32'(req_pend), 32'h1);
        step();
        step();
        step();
        check("t5_gap", 32'(p_light), 32'h00);
        step();
        check("t5_rewalk",     32'(p_light),  32'h01);
        check("t5_req_served", 32'(req_pend), 32'h0);
        repeat (13) step();

        // Second build: unmapped phase 17 never walks; mid-WALK reset clears at once.
        rst2 = 1'b1;
        st2  = 5'd17;
        step();
        ps2 = 6'h3F;
        step();
        ps2 = 6'h00;
        check("t6_no_walk",  32'(pl2), 32'h000);
        check("t6_latched",  32'(rq2), 32'h3F);
        repeat (3) step();
        check("t6_still_no", 32'(pl2),   32'h000);
        check("t6_no_hold",  32'(hold2), 32'h0);
        st2 = 5'd0;
        step();
        check("t6_walk",     32'(pl2), 32'h005);
        check("t6_req_left", 32'(rq2), 32'h3C);
        step();
        check("t6_walk2",    32'(pl2), 32'h005);
        rst2 = 1'b0;
        step();
        check("t6_rst_pl",   32'(pl2),   32'h000);
        check("t6_rst_req",  32'(rq2),   32'h00);
        check("t6_rst_hold", 32'(hold2), 32'h0);
        rst2 = 1'b1;
        st2  = 5'd4;
        ps2  = 6'h10;
        for (int j = 0; j < 3; j++) begin
            step();
            ps2 = 6'h00;
            check("t6_walk_b", 32'(pl2), 32'h100);
        end
        for (int j = 0; j < 2; j++) begin
            step();
            check("t6_flash_b", 32'(pl2), 32'h200);
        end
        step();
        check("t6_done_b", 32'(pl2), 32'h000);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pedestrian_crossing_n.md
Name: pedestrian_crossing_n

Overview:
Parametrised successor to the four-way pedestrian_crossing block. It serves NUM_XING crosswalks. For each crosswalk it latches button presses and decodes the vehicle phase from the intersection controller (state1) into a per-crosswalk "safe to walk" flag. Each crosswalk runs its own DONT_WALK/WALK/FLASH timer FSM. A hold request goes back to the intersection controller so it does not leave a phase while any walk or clearance interval is running.

Parameters:
NUM_XING, 4, number of crosswalks. Index 0=S, 1=N, 2=E, 3=W in the default build.
STATE_W, 5, width of the state1 phase code.
WALK_CYCLES, 8, clocks spent in WALK (must be ≥1).
FLASH_CYCLES, 4, clocks spent in FLASH clearance (must be ≥1).
SAFE_MAP, 64'h00C3, 16*NUM_XING bits. Bit (p*NUM_XING+i)=1 means crosswalk i may walk during phase p. Default: phase 0 (n_s) enables crosswalks 0 and 1; phase 1 (e_w) enables crosswalks 2 and 3; all other phases enable none.

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on the CLK rising edge)
state1  input  STATE_W  current vehicle phase code from the intersection controller
ps  input  NUM_XING  pedestrian push buttons, one per crosswalk, level input
p_light  output  2*NUM_XING  per-crosswalk lamp; field i is [2i+1:2i]. 00=DONT_WALK, 01=WALK, 10=FLASH, 11 never driven
req_pend  output  NUM_XING  latched request waiting to be served
hold_req  output  1  high while any crosswalk is in WALK or FLASH

Behaviour:
- Reset, when rst=0 at a CLK edge:
  - all p_light fields = 00, req_pend = 0, hold_req = 0.
  - internal ps_d = 0; all counters = 0; all FSMs = DONT_WALK.
  - Reset mid-WALK or mid-FLASH forces DONT_WALK on the same edge. No clearance is given.
- Press detect:
  - press[i] = ps[i] & ~ps_d[i]; ps_d is registered every cycle.
  - A held button counts once.
  - A button already high when reset releases counts as one press on the first active edge.
- Safe decode, combinational:
  - safe[i] = SAFE_MAP[state1*NUM_XING+i] when state1 < 16.
  - safe[i] = 0 when state1 ≥ 16.
- Request latch, per crosswalk:
  - Set on press[i].
  - Cleared on the edge where the FSM enters WALK.
  - A press on that same entry edge is absorbed; it does not re-set the latch.
  - A press during WALK or FLASH sets the latch again; it is served after a return to DONT_WALK.
- Per-crosswalk FSM:
  - DONT_WALK → WALK when (req_pend[i] | press[i]) & safe[i]. Latency: a press sampled at edge k with a safe phase gives p_light=01 after edge k. The counter loads WALK_CYCLES-1.
  - WALK: the counter decrements each clock.
    - At 0 → FLASH, counter loads FLASH_CYCLES-1. WALK therefore lasts exactly WALK_CYCLES clocks.
    - If safe[i]=0 during WALK → FLASH on that edge with a full FLASH_CYCLES count (abort).
  - FLASH: lasts exactly FLASH_CYCLES clocks regardless of safe, then → DONT_WALK.
  - DONT_WALK lasts at least 1 clock before any new WALK.
- hold_req is registered and equals OR over all crosswalks of (state is WALK or FLASH), as of that same edge.
- Crosswalks are fully independent. Simultaneous presses on several safe crosswalks all enter WALK on the same edge.
- Counter width is $clog2(max(WALK_CYCLES, FLASH_CYCLES)+1). Counters never wrap below 0.

Test Plan:
1. Reset: rst=0 for 2 edges with random ps/state1 → p_light=0, req_pend=0, hold_req=0.
2. Default params: state1=0, pulse ps[0] for 1 cycle → field 0 reads 01 for 8 clocks, then 10 for 4 clocks, then 00; field 1 stays 00; hold_req high for exactly 12 clocks.
3. state1=2 (n_s_y), pulse ps[2] → req_pend[2]=1 and p_light[5:4]=00. Change state1 to 1 → WALK on the next edge and req_pend[2] clears.
4. Abort: state1=1, pulse ps[3], wait 3 clocks in WALK, set state1=3 → field 3 goes to 10 on the next edge for 4 clocks, then 00.
5. Hold button ps[0]=1 for 30 clocks with state1=0 → exactly one WALK/FLASH cycle. Pulse again during FLASH → req_pend[0]=1, then a new WALK after 1 DONT_WALK clock.
6. Parameter sweep: NUM_XING=6, WALK_CYCLES=3, FLASH_CYCLES=2, state1=17 → no WALK on any press. Mid-WALK rst=0 → all fields 00 on the same edge.
